// File: rtl/sf_assoc.sv
// Set-associative snoop filter: per-line RN-F presence vector + U/S state, round-robin victim with back-invalidate.
// Latency: request accepted at T, lookup at T+1, response strobe and array write at T+2; one request per 3 cycles.
// Backpressure: i_req_valid is held off (o_req_ready=0) outside IDLE; a back-invalidate stalls the FSM until i_binv_ready.
//
// Ports:
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   i_req_valid/o_req_ready             request handshake; i_req_addr, i_req_op (0 RS, 1 RU, 2 Evict, 3 lookup), i_req_src
//   o_rsp_valid                         single-cycle strobe with pre-update o_rsp_hit/o_rsp_state/o_rsp_rnvec
//   o_binv_valid/i_binv_ready           back-invalidate handshake; o_binv_addr (line aligned), o_binv_vec
module sf_assoc #(
    parameter int ADDR_W   = 48,
    parameter int OFFSET_W = 6,
    parameter int SET_W    = 7,
    parameter int WAYS     = 4,
    parameter int NUM_RN   = 4,
    localparam int SRC_W   = (NUM_RN > 1) ? $clog2(NUM_RN) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [1:0]        i_req_op,
    input  logic [SRC_W-1:0]  i_req_src,
    output logic              o_rsp_valid,
    output logic              o_rsp_hit,
    output logic [1:0]        o_rsp_state,
    output logic [NUM_RN-1:0] o_rsp_rnvec,
    output logic              o_binv_valid,
    input  logic              i_binv_ready,
    output logic [ADDR_W-1:0] o_binv_addr,
    output logic [NUM_RN-1:0] o_binv_vec
);

    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int SETS   = 1 << SET_W;
    localparam int LINE_W = ADDR_W - OFFSET_W;
    localparam int TAG_W  = LINE_W - SET_W;

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_U = 2'b10;

    localparam logic [1:0] OP_RS = 2'd0;
    localparam logic [1:0] OP_RU = 2'd1;
    localparam logic [1:0] OP_EV = 2'd2;

    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_LOOKUP = 2'd1,
        FSM_UPDATE = 2'd2,
        FSM_BINV   = 2'd3
    } fsm_t;

    fsm_t                    r_state;
    logic                    r_req_ready;
    logic [LINE_W-1:0]       r_line;
    logic [1:0]              r_op;
    logic [SRC_W-1:0]        r_src;
    logic                    r_rsp_valid;
    logic                    r_rsp_hit;
    logic [1:0]              r_rsp_state;
    logic [NUM_RN-1:0]       r_rsp_vec;
    logic                    r_binv_valid;
    logic [LINE_W-1:0]       r_binv_line;
    logic [NUM_RN-1:0]       r_binv_vec;

    // Valid bits and round-robin pointers need reset, so they live in packed arrays.
    logic [SETS-1:0][WAYS-1:0]  r_valid;
    logic [SETS-1:0][WAY_W-1:0] r_rr;

    // Payload arrays are only ever read under a valid bit, so they carry no reset.
    logic [TAG_W-1:0]        r_tag [SETS][WAYS];
    logic [1:0]              r_st  [SETS][WAYS];
    logic [NUM_RN-1:0]       r_vec [SETS][WAYS];

    logic [SET_W-1:0]        w_set;
    logic [TAG_W-1:0]        w_tag;
    logic [NUM_RN-1:0]       w_src_bit;
    logic [WAYS-1:0]         w_hit_oh;
    logic                    w_hit;
    logic [WAY_W-1:0]        w_hit_way;
    logic [1:0]              w_hit_st;
    logic [NUM_RN-1:0]       w_hit_vec;
    logic [WAY_W-1:0]        w_inv_way;
    logic                    w_full;
    logic                    w_wr_en;
    logic [WAY_W-1:0]        w_wr_way;
    logic                    w_wr_valid;
    logic [1:0]              w_wr_st;
    logic [NUM_RN-1:0]       w_wr_vec;
    logic                    w_evict;
    logic [LINE_W-1:0]       w_vic_line;
    logic [NUM_RN-1:0]       w_vic_vec;
    logic [NUM_RN-1:0]       w_nv;
    logic                    w_unused;

    assign w_unused = ^i_req_addr[OFFSET_W-1:0];

    assign w_set     = r_line[SET_W-1:0];
    assign w_tag     = r_line[LINE_W-1:SET_W];
    assign w_src_bit = NUM_RN'(1) << r_src;
    assign w_full    = &r_valid[w_set];

    // A line held by exactly one RN-F is Unique, otherwise Shared.
    function automatic logic [1:0] derive_st(input logic [NUM_RN-1:0] v);
        return ((v & (v - NUM_RN'(1))) == '0) ? ST_U : ST_S;
    endfunction

    // Tag compare and way selection for the registered request.
    always_comb begin
        w_hit_oh  = '0;
        w_hit_way = '0;
        w_hit_st  = ST_I;
        w_hit_vec = '0;
        w_inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_hit_oh[w] = r_valid[w_set][w] && (r_tag[w_set][w] == w_tag);
            if (w_hit_oh[w]) begin
                w_hit_way = WAY_W'(w);
                w_hit_st  = r_st[w_set][w];
                w_hit_vec = r_vec[w_set][w];
            end
        end
        // Scan downwards so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_set][w]) begin
                w_inv_way = WAY_W'(w);
            end
        end
    end

    assign w_hit      = |w_hit_oh;
    assign w_vic_line = {r_tag[w_set][r_rr[w_set]], w_set};
    assign w_vic_vec  = r_vec[w_set][r_rr[w_set]];

    // Next tracking state for the addressed line.
    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_way   = w_hit_way;
        w_wr_valid = 1'b1;
        w_wr_st    = ST_U;
        w_wr_vec   = w_src_bit;
        w_evict    = 1'b0;
        w_nv       = '0;
        if (w_hit) begin
            case (r_op)
                OP_RS: begin
                    w_nv     = w_hit_vec | w_src_bit;
                    w_wr_en  = 1'b1;
                    w_wr_vec = w_nv;
                    w_wr_st  = derive_st(w_nv);
                end
                OP_RU: begin
                    w_wr_en = 1'b1;
                end
                OP_EV: begin
                    w_nv       = w_hit_vec & ~w_src_bit;
                    w_wr_en    = 1'b1;
                    w_wr_vec   = w_nv;
                    w_wr_valid = (w_nv != '0);
                    w_wr_st    = derive_st(w_nv);
                end
                default: ;
            endcase
        end else if (r_op == OP_RS || r_op == OP_RU) begin
            w_wr_en = 1'b1;
            if (w_full) begin
                w_wr_way = r_rr[w_set];
                w_evict  = 1'b1;
            end else begin
                w_wr_way = w_inv_way;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= FSM_IDLE;
            r_req_ready  <= 1'b0;
            r_line       <= '0;
            r_op         <= '0;
            r_src        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_hit    <= 1'b0;
            r_rsp_state  <= ST_I;
            r_rsp_vec    <= '0;
            r_binv_valid <= 1'b0;
            r_binv_line  <= '0;
            r_binv_vec   <= '0;
            r_valid      <= '0;
            r_rr         <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                FSM_IDLE: begin
                    if (r_req_ready && i_req_valid) begin
                        r_line      <= i_req_addr[ADDR_W-1:OFFSET_W];
                        r_op        <= i_req_op;
                        r_src       <= i_req_src;
                        r_req_ready <= 1'b0;
                        r_state     <= FSM_LOOKUP;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                FSM_LOOKUP: begin
                    // Response and array write both land at the edge into UPDATE.
                    r_rsp_valid <= 1'b1;
                    r_rsp_hit   <= w_hit;
                    r_rsp_state <= w_hit ? w_hit_st : ST_I;
                    r_rsp_vec   <= w_hit ? w_hit_vec : '0;
                    if (w_wr_en) begin
                        r_valid[w_set][w_wr_way] <= w_wr_valid;
                    end
                    if (w_evict) begin
                        r_rr[w_set]  <= r_rr[w_set] + WAY_W'(1);
                        r_binv_valid <= 1'b1;
                        r_binv_line  <= w_vic_line;
                        r_binv_vec   <= w_vic_vec;
                    end
                    r_state <= FSM_UPDATE;
                end
                FSM_UPDATE: begin
                    if (r_binv_valid && !i_binv_ready) begin
                        r_state <= FSM_BINV;
                    end else begin
                        r_binv_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= FSM_IDLE;
                    end
                end
                FSM_BINV: begin
                    if (i_binv_ready) begin
                        r_binv_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= FSM_IDLE;
                    end
                end
                default: r_state <= FSM_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_state == FSM_LOOKUP && w_wr_en) begin
            r_tag[w_set][w_wr_way] <= w_tag;
            r_st[w_set][w_wr_way]  <= w_wr_st;
            r_vec[w_set][w_wr_way] <= w_wr_vec;
        end
    end

    a_single_hit: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (r_state == FSM_LOOKUP) |-> $onehot0(w_hit_oh));

    assign o_req_ready  = r_req_ready;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_hit    = r_rsp_hit;
    assign o_rsp_state  = r_rsp_state;
    assign o_rsp_rnvec  = r_rsp_vec;
    assign o_binv_valid = r_binv_valid;
    assign o_binv_addr  = {r_binv_line, {OFFSET_W{1'b0}}};
    assign o_binv_vec   = r_binv_vec;

endmodule

// File: tb/tb_sf_assoc.sv
// Bench for sf_assoc: directed vector table, reset-during-lookup sequence, then random traffic vs. a reference model.
// Latency: checks response at T+2 and req_ready at T+3 after each accept.
// Backpressure: holds binv_ready low for a per-request number of cycles.
module tb_sf_assoc;

    localparam int ADDR_W = 48;
    localparam int WAYS   = 4;
    localparam int SETS   = 128;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [47:0] i_req_addr = '0;
    logic [1:0]  i_req_op = '0;
    logic [1:0]  i_req_src = '0;
    logic        o_rsp_valid;
    logic        o_rsp_hit;
    logic [1:0]  o_rsp_state;
    logic [3:0]  o_rsp_rnvec;
    logic        o_binv_valid;
    logic        i_binv_ready = 1'b0;
    logic [47:0] o_binv_addr;
    logic [3:0]  o_binv_vec;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    sf_assoc dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_addr  (i_req_addr),
        .i_req_op    (i_req_op),
        .i_req_src   (i_req_src),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_hit   (o_rsp_hit),
        .o_rsp_state (o_rsp_state),
        .o_rsp_rnvec (o_rsp_rnvec),
        .o_binv_valid(o_binv_valid),
        .i_binv_ready(i_binv_ready),
        .o_binv_addr (o_binv_addr),
        .o_binv_vec  (o_binv_vec)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: each set is a list of WAYS tracked lines plus a replacement pointer.
    bit          m_v   [SETS][WAYS];
    logic [34:0] m_tag [SETS][WAYS];
    logic [3:0]  m_vec [SETS][WAYS];
    logic [1:0]  m_st  [SETS][WAYS];
    int          m_rr  [SETS];

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_v[s][w] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [47:0] a, input logic [1:0] op, input logic [1:0] src,
                              output logic e_hit, output logic [1:0] e_st, output logic [3:0] e_vec,
                              output logic e_binv, output logic [47:0] e_baddr, output logic [3:0] e_bvec);
        int s, hw, fw;
        logic [34:0] t;
        logic [3:0]  b, nv;
        s  = int'(a[12:6]);
        t  = a[47:13];
        b  = 4'b0001 << src;
        hw = -1;
        fw = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_v[s][w] && m_tag[s][w] == t) hw = w;
        e_hit   = (hw >= 0);
        e_st    = e_hit ? m_st[s][hw] : 2'b00;
        e_vec   = e_hit ? m_vec[s][hw] : 4'b0000;
        e_binv  = 1'b0;
        e_baddr = '0;
        e_bvec  = '0;
        if (hw >= 0) begin
            case (op)
                2'd0: begin
                    nv = m_vec[s][hw] | b;
                    m_vec[s][hw] = nv;
                    m_st[s][hw]  = ($countones(nv) == 1) ? 2'b10 : 2'b01;
                end
                2'd1: begin
                    m_vec[s][hw] = b;
                    m_st[s][hw]  = 2'b10;
                end
                2'd2: begin
                    nv = m_vec[s][hw] & ~b;
                    m_vec[s][hw] = nv;
                    if (nv == 4'b0000) m_v[s][hw] = 1'b0;
                    else m_st[s][hw] = ($countones(nv) == 1) ? 2'b10 : 2'b01;
                end
                default: ;
            endcase
        end else if (op == 2'd0 || op == 2'd1) begin
            for (int w = WAYS - 1; w >= 0; w--)
                if (!m_v[s][w]) fw = w;
            if (fw < 0) begin
                fw      = m_rr[s];
                e_binv  = 1'b1;
                e_baddr = {m_tag[s][fw], a[12:6], 6'b000000};
                e_bvec  = m_vec[s][fw];
                m_rr[s] = (m_rr[s] + 1) % WAYS;
            end
            m_v[s][fw]   = 1'b1;
            m_tag[s][fw] = t;
            m_vec[s][fw] = b;
            m_st[s][fw]  = 2'b10;
        end
    endtask

    // Issue one request; drives at negedges, samples at negedges; hold = cycles binv_ready stays low.
    task automatic issue(input logic [47:0] a, input logic [1:0] op, input logic [1:0] src, input int hold,
                         output logic g_hit, output logic [1:0] g_st, output logic [3:0] g_vec,
                         output logic g_binv, output logic [47:0] g_baddr, output logic [3:0] g_bvec);
        int n;
        n = 0;
        while (!o_req_ready && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_req_ready) chk("req_ready_timeout", 64'(o_req_ready), 64'd1);
        i_req_valid  = 1'b1;
        i_req_addr   = a;
        i_req_op     = op;
        i_req_src    = src;
        i_binv_ready = (hold == 0);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        chk("lookup_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("lookup_req_ready", 64'(o_req_ready), 64'd0);
        @(negedge i_clk);
        chk("update_rsp_valid", 64'(o_rsp_valid), 64'd1);
        g_hit   = o_rsp_hit;
        g_st    = o_rsp_state;
        g_vec   = o_rsp_rnvec;
        g_binv  = o_binv_valid;
        g_baddr = o_binv_addr;
        g_bvec  = o_binv_vec;
        if (g_binv && hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge i_clk);
                chk("binv_hold_valid", 64'(o_binv_valid), 64'd1);
                chk("binv_hold_addr", 64'(o_binv_addr), 64'(g_baddr));
                chk("binv_hold_vec", 64'(o_binv_vec), 64'(g_bvec));
                chk("binv_hold_req_ready", 64'(o_req_ready), 64'd0);
            end
            i_binv_ready = 1'b1;
        end
        @(negedge i_clk);
        i_binv_ready = 1'b0;
        chk("idle_req_ready", 64'(o_req_ready), 64'd1);
        chk("idle_binv_valid", 64'(o_binv_valid), 64'd0);
        chk("idle_rsp_valid", 64'(o_rsp_valid), 64'd0);
    endtask

    typedef struct {
        logic [47:0] addr;
        logic [1:0]  op;
        logic [1:0]  src;
        int          hold;
        logic        hit;
        logic [1:0]  st;
        logic [3:0]  vec;
        logic        binv;
        logic [47:0] baddr;
        logic [3:0]  bvec;
    } vec_t;

    function automatic vec_t mk(input logic [47:0] a, input logic [1:0] op, input logic [1:0] src, input int hold,
                                input logic hit, input logic [1:0] st, input logic [3:0] vec,
                                input logic binv, input logic [47:0] baddr, input logic [3:0] bvec);
        vec_t v;
        v.addr = a; v.op = op; v.src = src; v.hold = hold;
        v.hit = hit; v.st = st; v.vec = vec;
        v.binv = binv; v.baddr = baddr; v.bvec = bvec;
        return v;
    endfunction

    vec_t tbl [18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        g_hit, e_hit, g_binv, e_binv;
        logic [1:0]  g_st, e_st;
        logic [3:0]  g_vec, e_vec, g_bvec, e_bvec;
        logic [47:0] g_baddr, e_baddr, ra;
        logic [1:0]  rop, rsrc;
        int          rset;

        //              addr        op    src  hold hit st     vec      binv baddr       bvec
        tbl[0]  = mk(48'h1000,  2'd0, 2'd0, 0, 0, 2'b00, 4'b0000, 0, 48'h0,     4'b0000);
        tbl[1]  = mk(48'h1000,  2'd0, 2'd1, 0, 1, 2'b10, 4'b0001, 0, 48'h0,     4'b0000);
        tbl[2]  = mk(48'h1000,  2'd1, 2'd2, 0, 1, 2'b01, 4'b0011, 0, 48'h0,     4'b0000);
        tbl[3]  = mk(48'h1000,  2'd3, 2'd0, 0, 1, 2'b10, 4'b0100, 0, 48'h0,     4'b0000);
        tbl[4]  = mk(48'h2000,  2'd0, 2'd0, 0, 0, 2'b00, 4'b0000, 0, 48'h0,     4'b0000);
        tbl[5]  = mk(48'h4000,  2'd0, 2'd1, 0, 0, 2'b00, 4'b0000, 0, 48'h0,     4'b0000);
        tbl[6]  = mk(48'h6000,  2'd1, 2'd2, 0, 0, 2'b00, 4'b0000, 0, 48'h0,     4'b0000);
        tbl[7]  = mk(48'h8000,  2'd0, 2'd0, 0, 0, 2'b00, 4'b0000, 0, 48'h0,     4'b0000);
        tbl[8]  = mk(48'hA000,  2'd0, 2'd3, 5, 0, 2'b00, 4'b0000, 1, 48'h2000,  4'b0001);
        tbl[9]  = mk(48'hC000,  2'd1, 2'd1, 0, 0, 2'b00, 4'b0000, 1, 48'h4000,  4'b0010);
        tbl[10] = mk(48'h8000,  2'd2, 2'd0, 0, 1, 2'b10, 4'b0001, 0, 48'h0,     4'b0000);
        tbl[11] = mk(48'h8000,  2'd3, 2'd0, 0, 0, 2'b00, 4'b0000, 0, 48'h0,     4'b0000);
        tbl[12] = mk(48'hE000,  2'd0, 2'd2, 0, 0, 2'b00, 4'b0000, 0, 48'h0,     4'b0000);
        tbl[13] = mk(48'h10000, 2'd0, 2'd3, 2, 0, 2'b00, 4'b0000, 1, 48'h6000,  4'b0100);
        tbl[14] = mk(48'hA000,  2'd0, 2'd1, 0, 1, 2'b10, 4'b1000, 0, 48'h0,     4'b0000);
        tbl[15] = mk(48'hA000,  2'd2, 2'd3, 0, 1, 2'b01, 4'b1010, 0, 48'h0,     4'b0000);
        tbl[16] = mk(48'hA000,  2'd3, 2'd0, 0, 1, 2'b10, 4'b0010, 0, 48'h0,     4'b0000);
        tbl[17] = mk(48'h12000, 2'd2, 2'd0, 0, 0, 2'b00, 4'b0000, 0, 48'h0,     4'b0000);

        model_reset();

        // Reset state.
        repeat (3) @(negedge i_clk);
        chk("rst_req_ready", 64'(o_req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("rst_rsp_fields", 64'({o_rsp_hit, o_rsp_state, o_rsp_rnvec}), 64'd0);
        chk("rst_binv_valid", 64'(o_binv_valid), 64'd0);
        chk("rst_binv_fields", 64'({o_binv_addr, o_binv_vec}), 64'd0);
        i_rst_n = 1'b1;
        #1;
        chk("rst_release_ready_low", 64'(o_req_ready), 64'd0);
        @(negedge i_clk);
        chk("rst_release_ready_rise", 64'(o_req_ready), 64'd1);

        // Directed table.
        for (int i = 0; i < 18; i++) begin
            model_step(tbl[i].addr, tbl[i].op, tbl[i].src, e_hit, e_st, e_vec, e_binv, e_baddr, e_bvec);
            issue(tbl[i].addr, tbl[i].op, tbl[i].src, tbl[i].hold, g_hit, g_st, g_vec, g_binv, g_baddr, g_bvec);
            chk($sformatf("vec%0d_hit", i), 64'(g_hit), 64'(tbl[i].hit));
            chk($sformatf("vec%0d_state", i), 64'(g_st), 64'(tbl[i].st));
            chk($sformatf("vec%0d_rnvec", i), 64'(g_vec), 64'(tbl[i].vec));
            chk($sformatf("vec%0d_binv", i), 64'(g_binv), 64'(tbl[i].binv));
            if (tbl[i].binv) begin
                chk($sformatf("vec%0d_binv_addr", i), 64'(g_baddr), 64'(tbl[i].baddr));
                chk($sformatf("vec%0d_binv_vec", i), 64'(g_bvec), 64'(tbl[i].bvec));
            end
        end

        // Reset asserted while the request is in LOOKUP.
        @(negedge i_clk);
        i_req_valid = 1'b1;
        i_req_addr  = 48'h20040;
        i_req_op    = 2'd0;
        i_req_src   = 2'd1;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        i_rst_n     = 1'b0;
        #1;
        chk("midrst_req_ready", 64'(o_req_ready), 64'd0);
        chk("midrst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("midrst_rsp_fields", 64'({o_rsp_hit, o_rsp_state, o_rsp_rnvec}), 64'd0);
        chk("midrst_binv", 64'({o_binv_valid, o_binv_addr, o_binv_vec}), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            chk("midrst_no_rsp", 64'(o_rsp_valid), 64'd0);
            chk("midrst_no_binv", 64'(o_binv_valid), 64'd0);
        end
        issue(48'h20040, 2'd3, 2'd1, 0, g_hit, g_st, g_vec, g_binv, g_baddr, g_bvec);
        chk("midrst_same_addr_miss", 64'({g_hit, g_st, g_vec}), 64'd0);
        issue(48'h1000, 2'd3, 2'd0, 0, g_hit, g_st, g_vec, g_binv, g_baddr, g_bvec);
        chk("midrst_old_line_miss", 64'({g_hit, g_st, g_vec}), 64'd0);

        // Random traffic concentrated on three sets and eight tags to force hits and evictions.
        for (int i = 0; i < 300; i++) begin
            rset = $urandom_range(0, 2);
            ra   = '0;
            ra[47:13] = 35'($urandom_range(0, 7));
            ra[12:6]  = (rset == 0) ? 7'd0 : (rset == 1) ? 7'd1 : 7'd127;
            ra[5:0]   = 6'($urandom_range(0, 63));
            rop  = 2'($urandom_range(0, 3));
            rsrc = 2'($urandom_range(0, 3));
            model_step(ra, rop, rsrc, e_hit, e_st, e_vec, e_binv, e_baddr, e_bvec);
            issue(ra, rop, rsrc, $urandom_range(0, 3), g_hit, g_st, g_vec, g_binv, g_baddr, g_bvec);
            chk("rand_hit", 64'(g_hit), 64'(e_hit));
            chk("rand_state", 64'(g_st), 64'(e_st));
            chk("rand_rnvec", 64'(g_vec), 64'(e_vec));
            chk("rand_binv", 64'(g_binv), 64'(e_binv));
            if (e_binv) begin
                chk("rand_binv_addr", 64'(g_baddr), 64'(e_baddr));
                chk("rand_binv_vec", 64'(g_bvec), 64'(e_bvec));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
